// File: rtl/audio_i2s_tx.sv
// I2S transmitter: stereo samples from a 1-deep holding register are serialised MSB first,
// with sclk derived from clk and lrclk leading the MSB of each word by one bit.
module audio_i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CLK_DIV      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      s_valid,
  input  logic [2*SAMPLE_WIDTH-1:0] s_data,
  output logic                      s_ready,
  output logic                      sclk,
  output logic                      lrclk,
  output logic                      sdata,
  output logic                      underrun
);

  localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SAMPLE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_BITS - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt, bit_nxt;
  logic                   full;
  logic [FRAME_BITS-1:0]  hold_data;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic                   div_tick, sclk_fall, frame_start, load, accept;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    div_tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    sclk_fall   = div_tick && sclk;
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    frame_start = sclk_fall && (bit_nxt == '0);
    load        = frame_start && (state == RUN);
    accept      = s_valid && !full;
  end

  assign s_ready = ~full;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)      state_nxt = RUN;
      RUN:     if (!enable)     state_nxt = DRAIN;
      DRAIN:   if (frame_start) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) full <= 1'b0;
    else if (load)   full <= 1'b0;
    else if (accept) full <= 1'b1;
  end

  // NOTE: the holding data needs no reset; its contents are only ever used while full is set.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      bit_cnt   <= BIT_LAST;
      sclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      shift_reg <= '0;
    end else begin
      underrun <= 1'b0;
      if (state == IDLE || (state == DRAIN && frame_start)) begin
        div_cnt   <= '0;
        bit_cnt   <= BIT_LAST;
        sclk      <= 1'b0;
        lrclk     <= 1'b0;
        sdata     <= 1'b0;
        shift_reg <= '0;
      end else begin
        if (div_tick) begin
          div_cnt <= '0;
          sclk    <= ~sclk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        // Data and word select move only on sclk falling edges, so they are stable at the rise.
        if (sclk_fall) begin
          bit_cnt <= bit_nxt;
          lrclk   <= (bit_nxt >= LR_FIRST) && (bit_nxt <= LR_LAST);
          if (frame_start) begin
            if (full) begin
              shift_reg <= {hold_data[FRAME_BITS-2:0], 1'b0};
              sdata     <= hold_data[FRAME_BITS-1];
            end else begin
              shift_reg <= '0;
              sdata     <= 1'b0;
              underrun  <= 1'b1;
            end
          end else begin
            sdata     <= shift_reg[FRAME_BITS-1];
            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per channel sample.
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period (legal ≥1).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  start/stop request for serial output.
REQ-006 SHALL have port s_valid  input  1  stereo sample valid.
REQ-007 SHALL have port s_data  input  2*SAMPLE_WIDTH  {left, right}, left in upper half.
REQ-008 SHALL have port s_ready  output  1  holding register empty, sample accepted when s_valid&s_ready.
REQ-009 SHALL have port sclk  output  1  I2S bit clock.
REQ-010 SHALL have port lrclk  output  1  I2S word select, 0 = left, 1 = right.
REQ-011 SHALL have port sdata  output  1  I2S serial data, MSB first.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse, frame started with no sample.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN.
- IDLE -> RUN on a cycle with enable=1.
- RUN -> DRAIN on a cycle with enable=0.
- DRAIN -> IDLE at the frame-end falling edge.
- DRAIN ignores enable.
REQ-014 SHALL behave in IDLE as follows:
- sclk=0, lrclk=0, sdata=0.
- div_cnt=0.
- bit_cnt=2*SAMPLE_WIDTH-1.
REQ-015 SHALL, in RUN and DRAIN, increment div_cnt each clk.
- At div_cnt=CLK_DIV-1: toggle sclk, div_cnt<=0.
- First sclk rise occurs CLK_DIV clks after entering RUN.
REQ-016 SHALL treat a toggle with sclk=1 as a falling edge.
- Only falling edges advance bit_cnt (2*SAMPLE_WIDTH-1 wraps to 0) and update sdata/lrclk, registered in the same cycle as sclk falls.
- sdata/lrclk are stable across the rising edge.
REQ-017 SHALL map slots as follows:
- Slot b=0..SAMPLE_WIDTH-1: sdata = left bit (SAMPLE_WIDTH-1-b).
- Slot b=SAMPLE_WIDTH..2*SAMPLE_WIDTH-1: sdata = right bit (2*SAMPLE_WIDTH-1-b).
REQ-018 SHALL drive lrclk=1 for slots SAMPLE_WIDTH-1..2*SAMPLE_WIDTH-2 and lrclk=0 otherwise (word select leads MSB by one bit, I2S standard).
REQ-019 SHALL hold a 1-deep holding register with flag full.
- s_ready = ~full, combinational from the flag.
- Acceptance sets full and captures s_data.
- Prefill is allowed in IDLE.
REQ-020 SHALL handle each falling edge entering slot 0 while in RUN as follows:
- If full: load shift register from holding register and clear full.
- Else: load all zeros and pulse underrun for exactly that cycle.
REQ-021 SHALL, in DRAIN, take the falling edge that would enter slot 0 as the frame end.
- Go to IDLE and zero outputs.
- No load, no underrun, holding register retained.
REQ-022 SHALL never allow acceptance and load on the same cycle, since a load requires full=1 and therefore s_ready=0.
REQ-023 SHALL produce frame period 4*SAMPLE_WIDTH*CLK_DIV clks.
REQ-024 SHALL make s_data changes while s_valid=1 and s_ready=0 have no effect.

Reset
REQ-025 SHALL, on reset_n=0 (asynchronous), force:
- state=IDLE, full=0, s_ready=1.
- sclk=0, lrclk=0, sdata=0, underrun=0.
- shift register = 0.
REQ-026 SHALL, on reset mid-frame, terminate the frame immediately with no drain, and discard any buffered sample.
REQ-027 SHALL leave reset synchronously to clk: the first active edge after reset_n rises behaves as IDLE.

Verification (SAMPLE_WIDTH=16, CLK_DIV=2, frame=128 clks)
REQ-028 SHALL cover: prefill 0xA5A5_3C3C in IDLE, then enable=1.
- Required: s_ready=0 until slot-0 load.
- sdata over slots 0..31 = 1010010110100101 0011110000111100.
- lrclk=1 exactly during slots 15..30.
REQ-029 SHALL cover: enable=1 with no sample.
- Required: underrun pulses 1 cycle at each slot-0 falling edge, every 128 clks.
- sdata=0 throughout.
REQ-030 SHALL cover: back-to-back samples 0xFFFF_0000, 0x0001_8000 written as soon as s_ready rises.
- Required: two consecutive frames, no underrun.
- s_ready rises the cycle after each load.
REQ-031 SHALL cover: enable dropped at slot 5.
- Required: remainder of frame completes.
- IDLE entered at the slot-0 edge with sclk=0, lrclk=0, sdata=0.
- No underrun.
- A queued sample is retained and sent after re-enable.
REQ-032 SHALL cover: reset_n asserted at slot 20 with full=1.
- Required: outputs zero within the same cycle (asynchronous).
- s_ready=1.
- After release and enable, the first frame underruns.
REQ-033 SHALL cover: CLK_DIV=1 sanity.
- Required: sclk toggles every clk.
- Frame = 64 clks.
- Bit order identical to REQ-028.
